// File: rtl/nib_tx.sv
// Byte-to-nibble transmitter: each accepted byte goes out low nibble first,
// then high nibble, each held HOLD cycles, followed by a done pulse and GAP idle cycles.
module nib_tx #(
   parameter int HOLD = 1,
   parameter int GAP  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   input  logic       s_is_th,
   output logic [3:0] nib,
   output logic       threshold,
   output logic       higher,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_GAP
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
   localparam logic [3:0] GAP_LAST  = 4'((GAP > 0) ? (GAP - 1) : 0);

   state_t     r_state;
   state_t     w_nextState;
   logic [3:0] r_cnt;
   logic [3:0] w_nextCnt;
   logic [3:0] r_dataHi;
   logic       r_isTh;
   logic       w_latch;
   logic       w_xfer;
   logic [3:0] r_nib;
   logic [3:0] w_nib;
   logic       r_th;
   logic       w_th;
   logic       r_hi;
   logic       w_hi;
   logic       r_ready;
   logic       r_busy;
   logic       r_done;
   logic       w_done;

   // The low nibble goes straight to the bus on the transfer edge, so only
   // the high nibble and the select bit need to be kept for later.
   assign w_xfer = s_valid && r_ready;

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_nib       = r_nib;
      w_th        = r_th;
      w_hi        = r_hi;
      w_done      = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_nextState = S_LO;
               w_nextCnt   = 4'd0;
               w_nib       = s_data[3:0];
               w_th        = s_is_th;
               w_hi        = 1'b0;
               w_latch     = 1'b1;
            end
         end
         S_LO: begin
            if (r_cnt == HOLD_LAST) begin
               w_nextState = S_HI;
               w_nextCnt   = 4'd0;
               w_nib       = r_dataHi;
               w_th        = r_isTh;
               w_hi        = 1'b1;
            end else begin
               w_nextCnt = r_cnt + 4'd1;
            end
         end
         S_HI: begin
            if (r_cnt == HOLD_LAST) begin
               w_nextState = (GAP > 0) ? S_GAP : S_IDLE;
               w_nextCnt   = 4'd0;
               w_done      = 1'b1;
            end else begin
               w_nextCnt = r_cnt + 4'd1;
            end
         end
         S_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_nextState = S_IDLE;
               w_nextCnt   = 4'd0;
            end else begin
               w_nextCnt = r_cnt + 4'd1;
            end
         end
         default: begin
            w_nextState = S_IDLE;
            w_nextCnt   = 4'd0;
         end
      endcase
   end

   // Ready and busy are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_dataHi <= 4'd0;
         r_isTh   <= 1'b0;
         r_nib    <= 4'd0;
         r_th     <= 1'b0;
         r_hi     <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         if (w_latch) begin
            r_dataHi <= s_data[7:4];
            r_isTh   <= s_is_th;
         end
         r_nib   <= w_nib;
         r_th    <= w_th;
         r_hi    <= w_hi;
         r_ready <= (w_nextState == S_IDLE);
         r_busy  <= (w_nextState != S_IDLE);
         r_done  <= w_done;
      end
   end

   assign s_ready   = r_ready;
   assign nib       = r_nib;
   assign threshold = r_th;
   assign higher    = r_hi;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_nib_tx.sv
// Bench for nib_tx: three parameterisations share one stimulus stream and are
// compared every cycle against a cycle-index model of the word timeline.
module tb_nib_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sValid = 1'b0;
   logic [7:0] sData = 8'h00;
   logic       sIsTh = 1'b0;

   logic [3:0] nibO [3];
   logic       thO   [3];
   logic       hiO   [3];
   logic       rdyO  [3];
   logic       busyO [3];
   logic       doneO [3];
   logic [8:0] obs   [3];

   int         checks = 0;
   int         failures = 0;

   int         holdV [3] = '{1, 3, 2};
   int         gapV  [3] = '{1, 0, 3};
   int         k     [3];
   logic [7:0] mData [3];
   logic       mTh   [3];
   logic [8:0] expV  [3];

   always #5 clk = ~clk;

   nib_tx #(.HOLD(1), .GAP(1)) u0 (
      .clk(clk), .rst(rst), .s_valid(sValid), .s_ready(rdyO[0]), .s_data(sData),
      .s_is_th(sIsTh), .nib(nibO[0]), .threshold(thO[0]), .higher(hiO[0]),
      .busy(busyO[0]), .done(doneO[0]));
   nib_tx #(.HOLD(3), .GAP(0)) u1 (
      .clk(clk), .rst(rst), .s_valid(sValid), .s_ready(rdyO[1]), .s_data(sData),
      .s_is_th(sIsTh), .nib(nibO[1]), .threshold(thO[1]), .higher(hiO[1]),
      .busy(busyO[1]), .done(doneO[1]));
   nib_tx #(.HOLD(2), .GAP(3)) u2 (
      .clk(clk), .rst(rst), .s_valid(sValid), .s_ready(rdyO[2]), .s_data(sData),
      .s_is_th(sIsTh), .nib(nibO[2]), .threshold(thO[2]), .higher(hiO[2]),
      .busy(busyO[2]), .done(doneO[2]));

   // Observation vector layout: {nib[3:0], threshold, higher, ready, busy, done}
   assign obs[0] = {nibO[0], thO[0], hiO[0], rdyO[0], busyO[0], doneO[0]};
   assign obs[1] = {nibO[1], thO[1], hiO[1], rdyO[1], busyO[1], doneO[1]};
   assign obs[2] = {nibO[2], thO[2], hiO[2], rdyO[2], busyO[2], doneO[2]};

   function automatic logic [8:0] vec(input logic [3:0] n, input logic t, input logic h,
                                      input logic r, input logic b, input logic d);
      return {n, t, h, r, b, d};
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         k[i]    = 0;
         expV[i] = 9'd0;
      end
   endtask

   // k counts edges since a word was accepted: 1..HOLD low nibble, then
   // HOLD cycles high nibble, done on 2*HOLD+1, ready again at the word period.
   task automatic modelStep();
      int       per;
      int       h;
      logic [3:0] n;
      logic     t;
      logic     hi;
      if (!rst) begin
         modelReset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         h   = holdV[i];
         per = 2 * h + gapV[i] + 1;
         if (sValid && expV[i][2]) begin
            k[i]     = 1;
            mData[i] = sData;
            mTh[i]   = sIsTh;
         end else if (k[i] != 0) begin
            k[i] = (k[i] >= per) ? 0 : k[i] + 1;
         end
         n  = expV[i][8:5];
         t  = expV[i][4];
         hi = expV[i][3];
         if (k[i] >= 1 && k[i] <= h) begin
            n  = mData[i][3:0];
            t  = mTh[i];
            hi = 1'b0;
         end else if (k[i] > h && k[i] <= 2 * h) begin
            n  = mData[i][7:4];
            t  = mTh[i];
            hi = 1'b1;
         end
         expV[i] = vec(n, t, hi, (k[i] == 0 || k[i] == per),
                       (k[i] >= 1 && k[i] < per), (k[i] == 2 * h + 1));
      end
   endtask

   task automatic checkOutput();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== expV[i]) begin
            failures++;
            $display("[TB] FAIL model u%0d t=%0t got=%h want=%h", i, $time, obs[i], expV[i]);
         end
      end
   endtask

   task automatic checkLit(input string name, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic t);
      sValid = v;
      sData  = d;
      sIsTh  = t;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, sData, sIsTh);
   endtask

   task automatic doReset();
      rst = 1'b0;
      #1;
      modelReset();
      checkOutput();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      modelReset();
      #1;
      checkLit("reset_state", obs[0], 9'd0);
      checkOutput();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
      checkLit("ready_after_reset", obs[0], vec(4'h0, 0, 0, 1, 0, 0));

      // Single sample 0xA5 on HOLD=1, GAP=1
      applyStimulus(1'b1, 8'hA5, 1'b0);
      checkLit("a5_lo", obs[0], vec(4'h5, 0, 0, 0, 1, 0));
      applyStimulus(1'b0, 8'hA5, 1'b0);
      checkLit("a5_hi", obs[0], vec(4'hA, 0, 1, 0, 1, 0));
      tick();
      checkLit("a5_done", obs[0], vec(4'hA, 0, 1, 0, 1, 1));
      tick();
      checkLit("a5_ready", obs[0], vec(4'hA, 0, 1, 1, 0, 0));

      idle(20);
      checkLit("idle_hold", obs[0], vec(4'hA, 0, 1, 1, 0, 0));

      // Threshold 0x3C then sample 0x7E with valid held high
      applyStimulus(1'b1, 8'h3C, 1'b1);
      checkLit("b2b_c", obs[0], vec(4'hC, 1, 0, 0, 1, 0));
      applyStimulus(1'b1, 8'h7E, 1'b0);
      checkLit("b2b_3", obs[0], vec(4'h3, 1, 1, 0, 1, 0));
      applyStimulus(1'b1, 8'h7E, 1'b0);
      checkLit("b2b_done", obs[0], vec(4'h3, 1, 1, 0, 1, 1));
      applyStimulus(1'b1, 8'h7E, 1'b0);
      checkLit("b2b_idle", obs[0], vec(4'h3, 1, 1, 1, 0, 0));
      applyStimulus(1'b1, 8'h7E, 1'b0);
      checkLit("b2b_e", obs[0], vec(4'hE, 0, 0, 0, 1, 0));
      applyStimulus(1'b0, 8'h7E, 1'b0);
      checkLit("b2b_7", obs[0], vec(4'h7, 0, 1, 0, 1, 0));
      idle(12);

      // Data change during LO must not leak into the high nibble
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkLit("hold_lo", obs[0], vec(4'h5, 0, 0, 0, 1, 0));
      applyStimulus(1'b0, 8'hFF, 1'b0);
      checkLit("hold_hi", obs[0], vec(4'h5, 0, 1, 0, 1, 0));
      idle(12);

      // HOLD=3, GAP=0 sample 0x12
      applyStimulus(1'b1, 8'h12, 1'b0);
      checkLit("h3_lo0", obs[1], vec(4'h2, 0, 0, 0, 1, 0));
      sValid = 1'b0;
      tick();
      checkLit("h3_lo1", obs[1], vec(4'h2, 0, 0, 0, 1, 0));
      tick();
      checkLit("h3_lo2", obs[1], vec(4'h2, 0, 0, 0, 1, 0));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkLit("h3_hi", obs[1], vec(4'h1, 0, 1, 0, 1, 0));
      end
      tick();
      checkLit("h3_done_ready", obs[1], vec(4'h1, 0, 1, 1, 0, 1));
      idle(12);

      // Reset during HI of 0x9B, then a clean 0x01
      applyStimulus(1'b1, 8'h9B, 1'b0);
      applyStimulus(1'b0, 8'h9B, 1'b0);
      checkLit("9b_hi", obs[0], vec(4'h9, 0, 1, 0, 1, 0));
      rst = 1'b0;
      #1;
      checkLit("async_reset", obs[0], 9'd0);
      modelReset();
      tick();
      rst = 1'b1;
      tick();
      checkLit("post_reset_ready", obs[0], vec(4'h0, 0, 0, 1, 0, 0));
      applyStimulus(1'b1, 8'h01, 1'b0);
      checkLit("01_lo", obs[0], vec(4'h1, 0, 0, 0, 1, 0));
      applyStimulus(1'b0, 8'h01, 1'b0);
      checkLit("01_hi", obs[0], vec(4'h0, 0, 1, 0, 1, 0));
      tick();
      checkLit("01_done", obs[0], vec(4'h0, 0, 1, 0, 1, 1));

      // Randomised traffic with occasional resets, checked by the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 249) == 0) begin
            doReset();
         end else begin
            applyStimulus(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
